// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ requesters.
// One transaction at a time: latch winner, pulse mem_valid, wait for mem_ready (or time out), respond.
module mem_rr_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_REQ    = 4,
    parameter int GNT_W      = $clog2(NUM_REQ),
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            resp_ready,
    output logic [WIDTH-1:0]              resp_rdata,
    output logic                          resp_err,
    output logic [GNT_W-1:0]              grant_id,
    output logic                          busy,
    output logic                          mem_valid,
    output logic                          mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic                          mem_ready,
    input  logic [WIDTH-1:0]              mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    logic [GNT_W-1:0]        ptr;
    logic [CNT_W-1:0]        cnt;
    logic [GNT_W-1:0]        winner;
    logic                    found;
    int                      scan_idx;
    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]        wdata_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
        end
    end

    // First requester at or after ptr, wrapping, wins.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[GNT_W'(scan_idx)]) begin
                winner = GNT_W'(scan_idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wr_rd  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_ready <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        mem_wr_rd <= req_wr_rd[winner];
                        mem_addr  <= addr_arr[winner];
                        mem_wdata <= wdata_arr[winner];
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_valid <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        resp_rdata           <= mem_wr_rd ? '0 : mem_rdata;
                        resp_err             <= 1'b0;
                        resp_ready[grant_id] <= 1'b1;
                        state                <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Last allowed silent WAIT cycle: give up with an error response.
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            resp_rdata           <= '0;
                            resp_err             <= 1'b1;
                            resp_ready[grant_id] <= 1'b1;
                            state                <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_ready <= '0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    ptr        <= (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous memory between NUM_REQ requesters.
- Memory port protocol: valid/wr_rd/addr/wdata in, registered ready/rdata out; ready is asserted the cycle after valid is sampled.
- The block latches one request, issues a single-cycle valid pulse to the memory, waits for ready (with timeout) and returns a one-cycle response to the winning requester.

Parameters:
- WIDTH, 8, data width.
- DEPTH, 32, memory depth.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_REQ, 4, number of requesters; must be >= 2.
- GNT_W, $clog2(NUM_REQ), grant index width.
- TIMEOUT, 15, maximum number of WAIT cycles without mem_ready before an error response.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's resp_ready.
- req_wr_rd  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  requester i uses slice [i*WIDTH +: WIDTH].
- resp_ready  out  NUM_REQ  one-cycle completion pulse to the winning requester.
- resp_rdata  out  WIDTH  read data; valid while resp_ready is high.
- resp_err  out  1  high with resp_ready on timeout.
- grant_id  out  GNT_W  index of the current or last winner.
- busy  out  1  high in every state except IDLE.
- mem_valid  out  1  valid to the memory.
- mem_wr_rd  out  1  to the memory.
- mem_addr  out  ADDR_WIDTH  to the memory.
- mem_wdata  out  WIDTH  to the memory.
- mem_ready  in  1  from the memory.
- mem_rdata  in  WIDTH  from the memory.

Behaviour:
- Reset (res low, async): state = IDLE; ptr = 0; timeout counter = 0; every output is 0, including grant_id, mem_* and resp_*. A transaction in flight is abandoned with no response. On res release the block starts from IDLE.
- Every output is registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from ptr upward, modulo NUM_REQ.
  - Latch the winner's wr_rd/addr/wdata into mem_wr_rd/mem_addr/mem_wdata, load grant_id, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_valid = 1 for exactly this cycle; go to WAIT; clear the counter.
- WAIT:
  - mem_valid = 0.
  - If mem_ready = 1: capture mem_rdata (reads only; writes give 0) and go to RESP with err = 0.
  - Else increment the counter. When the counter reaches TIMEOUT, go to RESP with err = 1 and rdata = 0.
- RESP:
  - resp_ready[grant_id] = 1; resp_rdata and resp_err are valid.
  - ptr = (grant_id + 1) mod NUM_REQ; go to IDLE.
  - resp_* return to 0 the next cycle.
- Latency with a one-cycle memory: request seen in IDLE at cycle 0, ISSUE at cycle 1, WAIT at cycle 2, resp_ready at cycle 3. Peak throughput is one transaction per 4 cycles.
- Request fields are sampled only in IDLE. Changes to them, or dropping req_valid after the grant, do not affect the in-flight transaction, and the response pulse is still issued.
- A requester still holding req_valid in the cycle after its resp_ready is treated as a new request, but it has lowest priority because ptr has advanced past it.
- Simultaneous requests: exactly one is granted; the others wait and are never dropped.
- Starvation bound: a continuously asserted request is granted within NUM_REQ transactions.
- ptr wraps from NUM_REQ-1 to 0.
- mem_ready seen outside WAIT is ignored.
- mem_addr/mem_wr_rd/mem_wdata hold their values until the next latch in IDLE.

Test Plan:
- Requester 0 writes addr 5 = 8'hA5, then reads addr 5 -> write: resp_ready[0] pulses 3 cycles after request, resp_err = 0. Read: resp_rdata = 8'hA5.
- All 4 requesters assert in the same cycle after reset, each reading its own pre-written address -> grant order 0,1,2,3, with resp_ready pulses 4 cycles apart, each with the correct data.
- Requesters 1 and 3 assert continuously, with ptr = 2 after a previous grant to 1 -> grants alternate 3,1,3,1; neither is starved.
- mem_ready tied low for a read from requester 2 -> resp_ready[2] and resp_err = 1 arrive after TIMEOUT WAIT cycles, resp_rdata = 0; the next request proceeds normally.
- res driven low during WAIT of a write -> all outputs 0 immediately, with no resp_ready. After release, ptr = 0 and a request from requester 0 completes normally.
- Requester 3 changes req_addr and drops req_valid during ISSUE -> the memory sees the original addr, and resp_ready[3] still pulses once.
